// File: rtl/regs_wb_pkg.sv
// Shared definitions for the write-back stage: widths, bus constants and the
// EX/WB latch action decode.
package regs_wb_pkg;

  localparam int RDATA_WIDTH    = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_NUM        = 32;

  localparam logic [RDATA_WIDTH-1:0] ZERO          = '0;
  localparam logic                   WRITE_ENABLE  = 1'b1;
  localparam logic                   WRITE_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    LATCH_LOAD  = 2'd0,
    LATCH_HOLD  = 2'd1,
    LATCH_CLEAR = 2'd2
  } latch_op_e;

  // Reset and flush both empty the latch; flush outranks stall.
  function automatic latch_op_e latch_op(input logic rst, input logic flush,
                                         input logic stall);
    if (rst || flush) return LATCH_CLEAR;
    if (stall)        return LATCH_HOLD;
    return LATCH_LOAD;
  endfunction

endpackage

// File: rtl/regs_wb_if.sv
// Execute/decode-facing bus of the write-back stage: incoming result, pipeline
// control, the two read ports and the pending-write view for hazard detection.
interface regs_wb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                     reg_we_in;
  logic        [ADDR_W-1:0] reg_waddr_in;
  logic signed [DATA_W-1:0] reg_wdata_in;
  logic                     stall_in;
  logic                     flush_in;
  logic        [ADDR_W-1:0] raddr1_in;
  logic        [ADDR_W-1:0] raddr2_in;
  logic signed [DATA_W-1:0] rdata1_out;
  logic signed [DATA_W-1:0] rdata2_out;
  logic                     wb_valid_out;
  logic        [ADDR_W-1:0] wb_waddr_out;
  logic signed [DATA_W-1:0] wb_wdata_out;

  modport master (
    output reg_we_in, reg_waddr_in, reg_wdata_in, stall_in, flush_in,
           raddr1_in, raddr2_in,
    input  rdata1_out, rdata2_out, wb_valid_out, wb_waddr_out, wb_wdata_out
  );

  modport slave (
    input  reg_we_in, reg_waddr_in, reg_wdata_in, stall_in, flush_in,
           raddr1_in, raddr2_in,
    output rdata1_out, rdata2_out, wb_valid_out, wb_waddr_out, wb_wdata_out
  );

endinterface

// File: rtl/regs_wb_file.sv
// Integer register array: one synchronous write port, two combinational read
// ports, index 0 hardwired to zero.
module regs_wb_file
  import regs_wb_pkg::*;
#(
  parameter int DATA_W   = RDATA_WIDTH,
  parameter int ADDR_W   = REG_ADDR_WIDTH,
  parameter int NUM_REGS = REG_NUM
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic        [ADDR_W-1:0] waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic        [ADDR_W-1:0] raddr1,
  input  logic        [ADDR_W-1:0] raddr2,
  output logic signed [DATA_W-1:0] rdata1,
  output logic signed [DATA_W-1:0] rdata2
);

  logic signed [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we == WRITE_ENABLE && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? ZERO[DATA_W-1:0] : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? ZERO[DATA_W-1:0] : regs[raddr2];

endmodule

// File: rtl/regs_wb.sv
// Write-back stage: EX/WB latch with stall/flush, commit into regs_wb_file.
// Define REGS_BYPASS_EN to forward the pending latch write onto the read ports.
module regs_wb
  import regs_wb_pkg::*;
#(
  parameter int DATA_W   = RDATA_WIDTH,
  parameter int ADDR_W   = REG_ADDR_WIDTH,
  parameter int NUM_REGS = REG_NUM
) (
  input  logic     clk_in,
  input  logic     reset_in,
  regs_wb_if.slave bus
);

  latch_op_e                op_p0;
  logic                     vld_p1;
  logic        [ADDR_W-1:0] waddr_p1;
  logic signed [DATA_W-1:0] wdata_p1;
  logic                     commit_p1;
  logic signed [DATA_W-1:0] arr_rdata1;
  logic signed [DATA_W-1:0] arr_rdata2;

  assign op_p0 = latch_op(reset_in, bus.flush_in, bus.stall_in);

  // ---- EX -> WB latch ----
  always_ff @(posedge clk_in) begin
    if (op_p0 == LATCH_CLEAR) begin
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else if (op_p0 == LATCH_LOAD) begin
      vld_p1   <= bus.reg_we_in && (bus.reg_waddr_in != '0);
      waddr_p1 <= bus.reg_waddr_in;
      wdata_p1 <= bus.reg_wdata_in;
    end
  end

  // ---- WB -> register array ----
  assign commit_p1 = (vld_p1 && !bus.stall_in && !bus.flush_in && !reset_in)
                     ? WRITE_ENABLE : WRITE_DISABLE;

  regs_wb_file #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_file (
    .clk   (clk_in),
    .rst   (reset_in),
    .we    (commit_p1),
    .waddr (waddr_p1),
    .wdata (wdata_p1),
    .raddr1(bus.raddr1_in),
    .raddr2(bus.raddr2_in),
    .rdata1(arr_rdata1),
    .rdata2(arr_rdata2)
  );

  assign bus.wb_valid_out = vld_p1;
  assign bus.wb_waddr_out = waddr_p1;
  assign bus.wb_wdata_out = wdata_p1;

`ifdef REGS_BYPASS_EN
  assign bus.rdata1_out = (vld_p1 && bus.raddr1_in == waddr_p1 && bus.raddr1_in != '0)
                          ? wdata_p1 : arr_rdata1;
  assign bus.rdata2_out = (vld_p1 && bus.raddr2_in == waddr_p1 && bus.raddr2_in != '0)
                          ? wdata_p1 : arr_rdata2;
`else
  assign bus.rdata1_out = arr_rdata1;
  assign bus.rdata2_out = arr_rdata2;
`endif

endmodule

// File: tb/tb_regs_wb.sv
// Self-checking bench for regs_wb: directed vector table, then randomized
// traffic against an architectural model of the register file and latch.
module tb_regs_wb;

`ifdef REGS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regs_wb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regs_wb dut (
    .clk_in  (clk),
    .reset_in(rst),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        stall, flush;
    logic [4:0]  ra1, ra2;
    logic        e_vld;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata, e_r1, e_r2;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic st, input logic fl, input logic [4:0] a1, input logic [4:0] a2,
                     input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                     input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v.rst = r; v.we = we; v.waddr = wa; v.wdata = wd; v.stall = st; v.flush = fl;
    v.ra1 = a1; v.ra2 = a2; v.e_vld = ev; v.e_waddr = ea; v.e_wdata = ed;
    v.e_r1 = e1; v.e_r2 = e2;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic st, input logic fl, input logic [4:0] a1, input logic [4:0] a2);
    rst = r;
    bus.reg_we_in = we; bus.reg_waddr_in = wa; bus.reg_wdata_in = wd;
    bus.stall_in = st;  bus.flush_in = fl;
    bus.raddr1_in = a1; bus.raddr2_in = a2;
  endtask

  // Architectural model: the register contents plus at most one pending write.
  logic [31:0] m_regs [32];
  bit          m_vld;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (BYP && m_vld && m_waddr == a) return m_wdata;
    return m_regs[a];
  endfunction

  task automatic m_step(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic st, input logic fl);
    if (r) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_vld = 0; m_waddr = 0; m_wdata = 0;
    end else begin
      if (m_vld && !st && !fl) m_regs[m_waddr] = m_wdata;
      if (fl) begin
        m_vld = 0; m_waddr = 0; m_wdata = 0;
      end else if (!st) begin
        m_vld = we && (wa != 0); m_waddr = wa; m_wdata = wd;
      end
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("reset wb_valid", {31'd0, bus.wb_valid_out}, 32'd0);
    check("reset wb_waddr", {27'd0, bus.wb_waddr_out}, 32'd0);
    check("reset wb_wdata", bus.wb_wdata_out, 32'd0);
    for (int i = 1; i < 32; i++) begin
      bus.raddr1_in = 5'(i);
      bus.raddr2_in = 5'(32 - i);
      #1;
      check($sformatf("reset x%0d port1", i), bus.rdata1_out, 32'd0);
      check($sformatf("reset x%0d port2", 32 - i), bus.rdata2_out, 32'd0);
    end

    //   rst we wa  wdata          st fl a1 a2  vld wa wdata         r1                        r2
    add(0, 1, 5, 32'h0000_1234,  0, 0, 5, 0,  0, 0, 32'h0,        32'h0,                    32'h0);
    add(0, 0, 0, 32'h0,          0, 0, 5, 5,  1, 5, 32'h0000_1234, BYP ? 32'h1234 : 32'h0,   BYP ? 32'h1234 : 32'h0);
    add(0, 0, 0, 32'h0,          0, 0, 5, 0,  0, 0, 32'h0,        32'h1234,                 32'h0);
    add(0, 1, 0, 32'hFFFF_FFFF,  0, 0, 0, 5,  0, 0, 32'h0,        32'h0,                    32'h1234);
    add(0, 0, 0, 32'h0,          0, 0, 0, 0,  0, 0, 32'hFFFF_FFFF, 32'h0,                   32'h0);
    add(0, 1, 7, 32'hAAAA_5555,  0, 0, 7, 5,  0, 0, 32'h0,        32'h0,                    32'h1234);
    for (int k = 0; k < 3; k++)
      add(0, 1, 8, 32'h1111_1111, 1, 0, 7, 8,  1, 7, 32'hAAAA_5555, BYP ? 32'hAAAA_5555 : 32'h0, 32'h0);
    add(0, 0, 0, 32'h0,          0, 0, 7, 8,  1, 7, 32'hAAAA_5555, BYP ? 32'hAAAA_5555 : 32'h0, 32'h0);
    add(0, 0, 0, 32'h0,          0, 0, 7, 8,  0, 0, 32'h0,        32'hAAAA_5555,            32'h0);
    add(0, 1, 9, 32'h0000_0042,  0, 0, 9, 7,  0, 0, 32'h0,        32'h0,                    32'hAAAA_5555);
    add(0, 0, 0, 32'h0,          0, 0, 9, 9,  1, 9, 32'h42,       BYP ? 32'h42 : 32'h0,     BYP ? 32'h42 : 32'h0);
    add(0, 1, 9, 32'hDEAD_BEEF,  0, 0, 9, 0,  0, 0, 32'h0,        32'h42,                   32'h0);
    add(0, 1, 10, 32'h5,         1, 1, 9, 10, 1, 9, 32'hDEAD_BEEF, BYP ? 32'hDEAD_BEEF : 32'h42, 32'h0);
    add(0, 0, 0, 32'h0,          0, 0, 9, 10, 0, 0, 32'h0,        32'h42,                   32'h0);
    add(0, 1, 3, 32'h1,          0, 0, 3, 9,  0, 0, 32'h0,        32'h0,                    32'h42);
    add(0, 1, 3, 32'h2,          0, 0, 3, 3,  1, 3, 32'h1,        BYP ? 32'h1 : 32'h0,      BYP ? 32'h1 : 32'h0);
    add(1, 0, 0, 32'h0,          0, 0, 3, 9,  1, 3, 32'h2,        BYP ? 32'h2 : 32'h1,      32'h42);
    add(0, 0, 0, 32'h0,          0, 0, 3, 9,  0, 0, 32'h0,        32'h0,                    32'h0);
    add(0, 0, 0, 32'h0,          0, 0, 5, 7,  0, 0, 32'h0,        32'h0,                    32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].we, tbl[i].waddr, tbl[i].wdata,
            tbl[i].stall, tbl[i].flush, tbl[i].ra1, tbl[i].ra2);
      #1;
      check($sformatf("vec%0d wb_valid", i), {31'd0, bus.wb_valid_out}, {31'd0, tbl[i].e_vld});
      check($sformatf("vec%0d wb_waddr", i), {27'd0, bus.wb_waddr_out}, {27'd0, tbl[i].e_waddr});
      check($sformatf("vec%0d wb_wdata", i), bus.wb_wdata_out, tbl[i].e_wdata);
      check($sformatf("vec%0d rdata1", i), bus.rdata1_out, tbl[i].e_r1);
      check($sformatf("vec%0d rdata2", i), bus.rdata2_out, tbl[i].e_r2);
      @(posedge clk); #1;
    end

    // Randomized traffic; addresses biased to a few registers to force collisions.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    m_step(1, 0, 0, 0, 0, 0);
    #1;
    for (int c = 0; c < 600; c++) begin
      logic        r, we, st, fl;
      logic [4:0]  wa, a1, a2;
      logic [31:0] wd;
      r  = ($urandom_range(99) < 2);
      we = ($urandom_range(99) < 75);
      st = ($urandom_range(99) < 20);
      fl = ($urandom_range(99) < 10);
      wa = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(5));
      a1 = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(5));
      a2 = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(5));
      wd = $urandom;
      drive(r, we, wa, wd, st, fl, a1, a2);
      #1;
      check($sformatf("rnd%0d wb_valid", c), {31'd0, bus.wb_valid_out}, {31'd0, m_vld});
      check($sformatf("rnd%0d wb_waddr", c), {27'd0, bus.wb_waddr_out}, {27'd0, m_waddr});
      check($sformatf("rnd%0d wb_wdata", c), bus.wb_wdata_out, m_wdata);
      check($sformatf("rnd%0d rdata1", c), bus.rdata1_out, m_read(a1));
      check($sformatf("rnd%0d rdata2", c), bus.rdata2_out, m_read(a2));
      @(posedge clk);
      m_step(r, we, wa, wd, st, fl);
      #1;
    end

    // Final sweep of the whole array against the model.
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      bus.raddr1_in = 5'(i);
      #1;
      check($sformatf("final x%0d", i), bus.rdata1_out, m_read(5'(i)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regs_wb.md
Name: regs_wb

Overview:
- Write-back stage directly downstream of the execute stage.
- Captures the execute result (write-enable, destination index, write data) in an EX/WB pipeline latch, then commits it to a 32x32 integer register file on the following clock.
- Provides the two combinational read ports consumed by decode, and exposes the pending write for hazard detection.
- Supports pipeline stall and flush.

Parameters:
- DATA_W, 32, register and write-data width (equals `RDATA_WIDTH).
- ADDR_W, 5, register index width.
- NUM_REGS, 32, number of architectural registers; index 0 is hardwired zero.

Ports:
- clk_in  input  1  core clock; all state updates on the rising edge.
- reset_in  input  1  synchronous, active-high reset.
- reg_we_in  input  1  write enable from execute.
- reg_waddr_in  input  ADDR_W  destination register index (rd from the instruction).
- reg_wdata_in  input  DATA_W  result from execute.
- stall_in  input  1  hold the latch and suppress the commit.
- flush_in  input  1  discard the latch contents.
- raddr1_in  input  ADDR_W  read port 1 index.
- raddr2_in  input  ADDR_W  read port 2 index.
- rdata1_out  output  DATA_W  read port 1 data.
- rdata2_out  output  DATA_W  read port 2 data.
- wb_valid_out  output  1  latch holds a pending write.
- wb_waddr_out  output  ADDR_W  pending destination index.
- wb_wdata_out  output  DATA_W  pending data.

Behaviour:
- Clocking and reset (already decided):
  - One clock, clk_in.
  - Reset reset_in is synchronous and active-high.
- Reset:
  - All NUM_REGS entries become 0.
  - Latch is invalid, so wb_valid_out=0, wb_waddr_out=0, wb_wdata_out=0.
  - Reset overrides stall and flush. Reset mid-operation discards the pending write with no commit.
- Latch capture, evaluated each edge in priority order:
  - reset_in: cleared.
  - flush_in: valid cleared, address and data cleared.
  - stall_in: hold.
  - Otherwise: valid <= reg_we_in && (reg_waddr_in != 0); address and data loaded.
- Commit:
  - On an edge where latch valid && !stall_in && !flush_in && !reset_in: regs[wb_waddr] <= wb_wdata.
  - Flush in the same cycle as a valid latch drops that write.
- Latency:
  - Result presented in cycle N is visible in wb_* during N+1.
  - It is committed to the array at the end of N+1 and readable from the array in N+2.
  - A stall adds one cycle per stalled cycle.
- Register x0:
  - Writes to index 0 never set latch valid and never modify the array.
  - A read of index 0 always returns 0.
- Reads:
  - Combinational from the array, no clock latency.
  - Both ports are independent and may read the same index.
- Back-to-back writes to the same index: each commits in order; the later value wins.
- Read of an index with a pending latch write: behaviour depends on REGS_BYPASS_EN (see Optional Feature).
- Simultaneous flush and stall: flush wins.

Optional Feature:
- Macro: REGS_BYPASS_EN.
- Defined:
  - If wb_valid_out && raddrX_in == wb_waddr_out && raddrX_in != 0, then rdataX_out = wb_wdata_out.
  - This applies even while stalled.
  - Decode can consume a result in cycle N+1.
- Undefined:
  - Reads return array contents only, i.e. the stale value until N+2.
  - The hazard unit must use wb_* to stall.

Decomposition:
- Shared defines.v: `RDATA_WIDTH, `ZERO, `WRITE_ENABLE/`WRITE_DISABLE, plus new `REG_ADDR_WIDTH (5) and `REG_NUM (32).
- One natural sub-module, regs_file: the array with one write port, two read ports, and x0 masking.
- regs_wb instantiates regs_file and adds the latch, stall/flush handling, and bypass muxes.

Test Plan:
- Reset, then read x1..x31 on both ports -> all 0; wb_valid_out=0.
- reg_we_in=1, waddr=5, wdata=0x0000_1234 in cycle N; read x5 -> N+1 returns 0x1234 with bypass, 0 without; N+2 returns 0x1234 in both builds.
- Write waddr=0, wdata=0xFFFF_FFFF -> wb_valid_out stays 0; x0 reads 0 forever.
- Write x7=0xAAAA_5555, assert stall_in for 3 cycles -> wb_* held, x7 array value unchanged; commit occurs on the first unstalled edge.
- Write x9=0xDEAD_BEEF, assert flush_in (together with stall_in) next cycle -> no commit; x9 remains at its previous value 0x0000_0042.
- Writes x3=1, x3=2 on consecutive cycles, then assert reset_in while x3=2 is pending -> x3=0, latch invalid; a subsequent read returns 0.
